msrv32_rf_wb_arbiter: RTL
=========================

# msrv32_rf_wb_arbiter

Write-side front end of the integer register file. It merges single-cycle ALU results with load results from the data-memory interface and drives the register file's single write port (rd address, rd data, write enable). Load results use a valid/ready handshake and are buffered in a small FIFO. The block exports a per-register pending-load scoreboard for the decode stall logic.

## Interface
Parameters:
- DEPTH, 2, load FIFO entries; power of two, 2..8.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- reset_in  input  1  asynchronous, active-high reset.
- alu_valid_in  input  1  ALU result present this cycle; always accepted, no backpressure.
- alu_rd_addr_in  input  5  ALU destination register.
- alu_result_in  input  32  ALU result.
- ld_valid_in  input  1  load result offered.
- ld_ready_out  output  1  load result accepted when high with ld_valid_in.
- ld_rd_addr_in  input  5  load destination register.
- ld_data_in  input  32  raw 32-bit word from data memory.
- ld_funct3_in  input  3  load type (RV32I funct3).
- ld_byte_off_in  input  2  byte address offset within the word.
- rd_addr_out  output  5  register-file write address.
- rd_out  output  32  register-file write data.
- wr_en_out  output  1  register-file write enable.
- busy_out  output  32  bit r high while any live FIFO entry targets register r.

## Operation
- Output stage is a register; rd_addr_out, rd_out and wr_en_out update only on a clock edge.
- Per-cycle selection for the next output, in priority order:
  - ALU, if alu_valid_in.
  - FIFO head, if FIFO is non-empty.
  - Load bypass, if FIFO is empty and ld_valid_in. The load is accepted and written directly without entering the FIFO.
  - Otherwise idle: wr_en_out is 0 next cycle.
- A load is accepted when ld_valid_in && ld_ready_out. It enqueues unless it took the bypass path.
- ld_ready_out = FIFO not full. It depends on registered state only, with no combinational path from inputs.
- Push and pop in the same cycle are allowed. Occupancy is then unchanged.
- x0 handling:
  - A write with rd = 0 from either source never asserts wr_en_out.
  - An x0 load is still accepted (handshake completes) but is discarded: no enqueue, no busy bit.
- WAW kill: when alu_valid_in is high, every live FIFO entry with rd equal to alu_rd_addr_in (nonzero) is marked killed in that cycle, because the ALU result is younger.
  - A killed entry still pops in its turn but produces wr_en_out = 0 for that cycle.
  - A killed entry no longer contributes to busy_out.
- busy_out is combinational from FIFO state: the OR, over live, non-killed entries, of the one-hot decode of the entry's rd.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. Occupancy is tracked with a count of log2(DEPTH)+1 bits.

## Timing
- Reset (asynchronous):
  - rd_addr_out = 0, rd_out = 0, wr_en_out = 0.
  - FIFO empty, all kill flags clear, busy_out = 0.
  - ld_ready_out = 1 once reset_in deasserts.
- ALU latency: valid in cycle t gives wr_en_out high in cycle t+1.
- Load via bypass: accepted in cycle t gives a write in cycle t+1.
- Load via FIFO: written in the first cycle after enqueue in which no ALU result is present.
- Sustained ALU traffic starves the FIFO by design. The pipeline guarantees ALU gaps.
- Full FIFO: ld_ready_out is low. A pop in cycle t raises ld_ready_out in cycle t+1.
- Reset mid-operation: queued loads are lost and any pending output write is cancelled immediately (wr_en_out drops asynchronously).

## Configuration
- LOAD_ALIGN_EN defined: load data is extracted and extended before enqueue or bypass.
  - funct3 000 (LB): sign-extended byte at ld_byte_off_in.
  - 100 (LBU): zero-extended byte at ld_byte_off_in.
  - 001 (LH): sign-extended halfword at ld_byte_off_in[1] (0 = bits 15:0, 1 = bits 31:16).
  - 101 (LHU): zero-extended halfword at the same position.
  - 010 and all other codes: full word.
- LOAD_ALIGN_EN undefined: ld_data_in is written unchanged. ld_funct3_in and ld_byte_off_in are ignored, and the extend logic is not synthesized.

## Test plan
- Reset, then ALU valid with rd = 5, result 0x1234_5678 → next cycle wr_en_out = 1, rd_addr_out = 5, rd_out = 0x1234_5678; the following cycle wr_en_out = 0.
- Load with rd = 7, data 0x0000_0080, funct3 000, offset 0, FIFO empty, no ALU → bypass, next cycle rd_out = 0xFFFF_FF80 with LOAD_ALIGN_EN and 0x0000_0080 without it.
- ALU valid for 4 consecutive cycles while loads rd = 1, 2, 3 arrive (DEPTH = 2):
  - After two pushes, ld_ready_out = 0 and busy_out = 0x0000_0006.
  - Queued loads write rd 1 then rd 2 in the two cycles after ALU traffic stops; the third load is then accepted.
- Queue load rd = 9, then ALU rd = 9 result 0xAAAA_AAAA → busy_out[9] clears, the ALU write occurs, and the later load pop gives wr_en_out = 0; register 9 keeps 0xAAAA_AAAA.
- Load rd = 0 and ALU rd = 0 → handshake completes, wr_en_out never asserts, busy_out stays 0.
- Assert reset_in with 2 entries queued and a write pending → wr_en_out falls asynchronously, busy_out = 0, and after release ld_ready_out = 1 with no stale writes.

Source files
------------

// File: rtl/msrv32_rf_wb_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : msrv32_rf_wb_arbiter
// Description : Register-file write-port arbiter. Merges single-cycle ALU
//               results with handshaked load results (buffered in a small
//               FIFO, or bypassed when the FIFO is empty) and exports a
//               per-register pending-load scoreboard (busy_out).
//               Optional build macro LOAD_ALIGN_EN: extract and sign/zero
//               extend load data by funct3 and byte offset before use.
// Revision    : 1.0 - initial release
// ============================================================================
module msrv32_rf_wb_arbiter #(
   parameter int DEPTH = 2
) (
   input  logic        clk_in,
   input  logic        reset_in,
   input  logic        alu_valid_in,
   input  logic [4:0]  alu_rd_addr_in,
   input  logic [31:0] alu_result_in,
   input  logic        ld_valid_in,
   output logic        ld_ready_out,
   input  logic [4:0]  ld_rd_addr_in,
   input  logic [31:0] ld_data_in,
   input  logic [2:0]  ld_funct3_in,
   input  logic [1:0]  ld_byte_off_in,
   output logic [4:0]  rd_addr_out,
   output logic [31:0] rd_out,
   output logic        wr_en_out,
   output logic [31:0] busy_out
);

   localparam int                 c_PTR_W     = $clog2(DEPTH);
   localparam int                 c_CNT_W     = c_PTR_W + 1;
   localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

   // FIFO storage and control state
   logic [4:0]         r_q_rd   [DEPTH];
   logic [31:0]        r_q_data [DEPTH];
   logic [DEPTH-1:0]   r_q_kill;
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [c_CNT_W-1:0] r_count;

   // Output stage registers
   logic [4:0]         r_rd_addr;
   logic [31:0]        r_rd_data;
   logic               r_wr_en;

   logic [31:0]        w_ld_data;
   logic [DEPTH-1:0]   w_live;
   logic [DEPTH-1:0]   w_match;
   logic               w_empty;
   logic               w_full;
   logic               w_ld_acc;
   logic               w_bypass;
   logic               w_push;
   logic               w_pop;
   logic               w_kill_hit;
   logic               w_nx_we;
   logic [4:0]         w_nx_rd;
   logic [31:0]        w_nx_data;
   logic [31:0]        w_busy;

`ifdef LOAD_ALIGN_EN
   logic [7:0]         w_ld_byte;
   logic [15:0]        w_ld_half;

   // Extract the addressed byte/halfword and extend it according to funct3
   always_comb begin
      w_ld_byte = ld_data_in[{ld_byte_off_in, 3'b000} +: 8];
      w_ld_half = ld_byte_off_in[1] ? ld_data_in[31:16] : ld_data_in[15:0];
      case (ld_funct3_in)
         3'b000:  w_ld_data = {{24{w_ld_byte[7]}}, w_ld_byte};
         3'b100:  w_ld_data = {24'd0, w_ld_byte};
         3'b001:  w_ld_data = {{16{w_ld_half[15]}}, w_ld_half};
         3'b101:  w_ld_data = {16'd0, w_ld_half};
         default: w_ld_data = ld_data_in;
      endcase
   end
`else
   // Raw word path; format inputs are intentionally ignored in this build
   logic w_unused_fmt;
   assign w_unused_fmt = ^{ld_funct3_in, ld_byte_off_in};
   assign w_ld_data    = ld_data_in;
`endif

   assign w_empty      = (r_count == '0);
   assign w_full       = (r_count == c_DEPTH_CNT);
   assign ld_ready_out = !w_full;

   // Liveness of each slot is its distance from the read pointer vs. occupancy
   for (genvar i = 0; i < DEPTH; i++) begin : g_live
      logic [c_PTR_W-1:0] w_dist;
      assign w_dist     = c_PTR_W'(i) - r_rd_ptr;
      assign w_live[i]  = ({1'b0, w_dist} < r_count);
      assign w_match[i] = w_live[i] && (r_q_rd[i] == alu_rd_addr_in);
   end

   assign w_ld_acc   = ld_valid_in && !w_full;
   assign w_bypass   = !alu_valid_in && w_empty && ld_valid_in;
   // x0 loads complete the handshake but are dropped rather than queued
   assign w_push     = w_ld_acc && !w_bypass && (ld_rd_addr_in != 5'd0);
   assign w_pop      = !alu_valid_in && !w_empty;
   assign w_kill_hit = alu_valid_in && (alu_rd_addr_in != 5'd0);

   // Pick next write source: ALU, then FIFO head, then load bypass
   always_comb begin
      w_nx_we   = 1'b0;
      w_nx_rd   = r_rd_addr;
      w_nx_data = r_rd_data;
      if (alu_valid_in) begin
         w_nx_we   = (alu_rd_addr_in != 5'd0);
         w_nx_rd   = alu_rd_addr_in;
         w_nx_data = alu_result_in;
      end else if (!w_empty) begin
         w_nx_we   = !r_q_kill[r_rd_ptr];
         w_nx_rd   = r_q_rd[r_rd_ptr];
         w_nx_data = r_q_data[r_rd_ptr];
      end else if (ld_valid_in) begin
         w_nx_we   = (ld_rd_addr_in != 5'd0);
         w_nx_rd   = ld_rd_addr_in;
         w_nx_data = w_ld_data;
      end
   end

   // Pending-load scoreboard: one-hot of each live, non-killed entry
   always_comb begin
      w_busy = 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
         if (w_live[i] && !r_q_kill[i]) begin
            w_busy = w_busy | (32'd1 << r_q_rd[i]);
         end
      end
   end
   assign busy_out = w_busy;

   // FIFO pointers, occupancy and kill flags
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_q_kill <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         // A younger ALU write to the same rd makes queued loads obsolete
         for (int i = 0; i < DEPTH; i++) begin
            if (w_push && (r_wr_ptr == c_PTR_W'(i))) begin
               r_q_kill[i] <= 1'b0;
            end else if (w_kill_hit && w_match[i]) begin
               r_q_kill[i] <= 1'b1;
            end
         end
      end
   end

   // FIFO payload storage; validity is carried by the pointers
   always_ff @(posedge clk_in) begin
      if (w_push) begin
         r_q_rd[r_wr_ptr]   <= ld_rd_addr_in;
         r_q_data[r_wr_ptr] <= w_ld_data;
      end
   end

   // Registered write port toward the register file
   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         r_wr_en   <= 1'b0;
         r_rd_addr <= 5'd0;
         r_rd_data <= 32'd0;
      end else begin
         r_wr_en   <= w_nx_we;
         r_rd_addr <= w_nx_rd;
         r_rd_data <= w_nx_data;
      end
   end

   assign wr_en_out   = r_wr_en;
   assign rd_addr_out = r_rd_addr;
   assign rd_out      = r_rd_data;

endmodule
`default_nettype wire
